// File: rtl/sdram_arbiter.sv
// sdram_arbiter: two-port arbiter in front of the SDRAM controller.
// Port 0 is instruction fetch and port 1 is load/store. Requests go out one at a
// time on the controller interface, and every output comes straight from a flop.
// Build option: define SDRAM_ARB_FIXED_PRIO_EN to give port 1 fixed priority.
// When it is not defined, the ports take turns (round-robin).
module sdram_arbiter #(
  parameter int unsigned ADDR_W = 25
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              m0_valid,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [31:0]       m0_wdata,
  input  logic [3:0]        m0_wmask,
  output logic [31:0]       m0_rdata,
  output logic              m0_ready,
  input  logic              m1_valid,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [31:0]       m1_wdata,
  input  logic [3:0]        m1_wmask,
  output logic [31:0]       m1_rdata,
  output logic              m1_ready,
  output logic              mem_valid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_din,
  output logic [3:0]        mem_wmask,
  input  logic [31:0]       mem_dout,
  input  logic              mem_ready
);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e            state_q, state_d;
  logic              grant_q, grant_d;
  logic              last_grant_q, last_grant_d;
  logic              mem_valid_q, mem_valid_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_din_q, mem_din_d;
  logic [3:0]        mem_wmask_q, mem_wmask_d;
  logic              m0_ready_q, m0_ready_d;
  logic              m1_ready_q, m1_ready_d;
  logic [31:0]       m0_rdata_q, m0_rdata_d;
  logic [31:0]       m1_rdata_q, m1_rdata_d;
  logic              pick;

  // Choose which port wins if a grant is made this cycle (1 = port 1).
  always_comb begin
    pick = m1_valid;
`ifdef SDRAM_ARB_FIXED_PRIO_EN
    // last_grant is still tracked below but has no effect in this build.
    if (m0_valid && m1_valid) pick = 1'b1;
`else
    if (m0_valid && m1_valid) pick = ~last_grant_q;
`endif
  end

  // Next-state logic and next values for the registered outputs.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    mem_valid_d  = mem_valid_q;
    mem_addr_d   = mem_addr_q;
    mem_din_d    = mem_din_q;
    mem_wmask_d  = mem_wmask_q;
    m0_ready_d   = 1'b0;
    m1_ready_d   = 1'b0;
    m0_rdata_d   = m0_rdata_q;
    m1_rdata_d   = m1_rdata_q;
    unique case (state_q)
      StIdle: begin
        mem_valid_d = 1'b0;
        if (m0_valid || m1_valid) begin
          grant_d      = pick;
          last_grant_d = pick;
          mem_valid_d  = 1'b1;
          // Force word alignment: bits [1:0] of the address are ignored.
          if (pick) begin
            mem_addr_d  = {m1_addr[ADDR_W-1:2], 2'b00};
            mem_din_d   = m1_wdata;
            mem_wmask_d = m1_wmask;
          end else begin
            mem_addr_d  = {m0_addr[ADDR_W-1:2], 2'b00};
            mem_din_d   = m0_wdata;
            mem_wmask_d = m0_wmask;
          end
          state_d = StBusy;
        end
      end
      StBusy: begin
        if (mem_ready) begin
          mem_valid_d = 1'b0;
          if (grant_q) begin
            m1_ready_d = 1'b1;
            if (mem_wmask_q == 4'd0) m1_rdata_d = mem_dout;
          end else begin
            m0_ready_d = 1'b1;
            if (mem_wmask_q == 4'd0) m0_rdata_d = mem_dout;
          end
          state_d = StDone;
        end
      end
      StDone: begin
        // No grant here, so a master has one cycle to drop or change its request.
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers. An asynchronous reset drops any access in flight.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= StIdle;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      mem_valid_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_din_q    <= '0;
      mem_wmask_q  <= '0;
      m0_ready_q   <= 1'b0;
      m1_ready_q   <= 1'b0;
      m0_rdata_q   <= '0;
      m1_rdata_q   <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      mem_valid_q  <= mem_valid_d;
      mem_addr_q   <= mem_addr_d;
      mem_din_q    <= mem_din_d;
      mem_wmask_q  <= mem_wmask_d;
      m0_ready_q   <= m0_ready_d;
      m1_ready_q   <= m1_ready_d;
      m0_rdata_q   <= m0_rdata_d;
      m1_rdata_q   <= m1_rdata_d;
    end
  end

  assign mem_valid = mem_valid_q;
  assign mem_addr  = mem_addr_q;
  assign mem_din   = mem_din_q;
  assign mem_wmask = mem_wmask_q;
  assign m0_ready  = m0_ready_q;
  assign m1_ready  = m1_ready_q;
  assign m0_rdata  = m0_rdata_q;
  assign m1_rdata  = m1_rdata_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed testbench for sdram_arbiter. The tasks below act as the SDRAM controller
// and as both masters. Inputs change on the falling edge, and outputs are sampled
// on the falling edge.
module tb_sdram_arbiter;

  localparam int ADDR_W = 25;

  logic              clk = 1'b0;
  logic              resetn;
  logic              m0_valid, m1_valid;
  logic [ADDR_W-1:0] m0_addr, m1_addr;
  logic [31:0]       m0_wdata, m1_wdata;
  logic [3:0]        m0_wmask, m1_wmask;
  logic [31:0]       m0_rdata, m1_rdata;
  logic              m0_ready, m1_ready;
  logic              mem_valid;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_din;
  logic [3:0]        mem_wmask;
  logic [31:0]       mem_dout;
  logic              mem_ready;

  int checks = 0;
  int errors = 0;

  // Values observed during the most recent call to serve().
  bit                s_ok;
  bit                s_stable;
  logic [ADDR_W-1:0] s_addr;
  logic [31:0]       s_din;
  logic [3:0]        s_wmask;
  logic              s_vld_after;
  logic [1:0]        s_rdy;
  logic [1:0]        s_rdy_after;
  logic [31:0]       s_rd0, s_rd1;

  sdram_arbiter #(.ADDR_W(ADDR_W)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .m0_valid (m0_valid),
    .m0_addr  (m0_addr),
    .m0_wdata (m0_wdata),
    .m0_wmask (m0_wmask),
    .m0_rdata (m0_rdata),
    .m0_ready (m0_ready),
    .m1_valid (m1_valid),
    .m1_addr  (m1_addr),
    .m1_wdata (m1_wdata),
    .m1_wmask (m1_wmask),
    .m1_rdata (m1_rdata),
    .m1_ready (m1_ready),
    .mem_valid(mem_valid),
    .mem_addr (mem_addr),
    .mem_din  (mem_din),
    .mem_wmask(mem_wmask),
    .mem_dout (mem_dout),
    .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  task automatic apply_reset();
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
  endtask

  // Controller model. It waits (up to a fixed bound) for mem_valid, holds the access
  // for lat cycles while checking that the fields do not change, then pulses
  // mem_ready for one cycle. It records readys and rdata at the next two samples.
  task automatic serve(input int lat, input logic [31:0] data);
    int n = 0;
    s_ok = 1'b0;
    s_stable = 1'b1;
    s_vld_after = 1'bx;
    s_rdy = 2'bxx;
    s_rdy_after = 2'bxx;
    while (mem_valid !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (mem_valid !== 1'b1) return;
    s_ok = 1'b1;
    s_addr = mem_addr;
    s_din = mem_din;
    s_wmask = mem_wmask;
    repeat (lat) begin
      @(negedge clk);
      if (mem_addr !== s_addr || mem_din !== s_din || mem_wmask !== s_wmask ||
          mem_valid !== 1'b1 || m0_ready !== 1'b0 || m1_ready !== 1'b0)
        s_stable = 1'b0;
    end
    mem_dout = data;
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    mem_dout = 32'h0;
    s_vld_after = mem_valid;
    s_rdy = {m1_ready, m0_ready};
    s_rd0 = m0_rdata;
    s_rd1 = m1_rdata;
    @(negedge clk);
    s_rdy_after = {m1_ready, m0_ready};
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    @(negedge clk);
    checks++;
    if ({mem_valid, mem_addr, mem_din, mem_wmask, m0_ready, m1_ready, m0_rdata, m1_rdata}
        !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got valid=%b addr=%h din=%h wm=%h r=%b%b rd0=%h rd1=%h expected all zero",
               mem_valid, mem_addr, mem_din, mem_wmask, m0_ready, m1_ready, m0_rdata, m1_rdata);
    end
    resetn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_read();
    m0_addr = 25'h0000100; m0_wmask = 4'h0; m0_wdata = 32'h0; m0_valid = 1'b1;
    serve(10, 32'hDEADBEEF);
    m0_valid = 1'b0;
    checks++;
    if (!s_ok) begin errors++; $display("FAIL read_grant: no mem_valid expected 1"); end
    checks++;
    if (s_addr !== 25'h0000100 || s_wmask !== 4'h0) begin
      errors++; $display("FAIL read_fields: got addr=%h wm=%h expected 0000100/0", s_addr, s_wmask);
    end
    checks++;
    if (s_rdy !== 2'b01) begin errors++; $display("FAIL read_ready: got %b expected 01", s_rdy); end
    checks++;
    if (s_rd0 !== 32'hDEADBEEF) begin
      errors++; $display("FAIL read_rdata: got %h expected deadbeef", s_rd0);
    end
    checks++;
    if (s_rdy_after !== 2'b00) begin
      errors++; $display("FAIL read_pulse_len: got %b expected 00", s_rdy_after);
    end
    checks++;
    if (!s_stable) begin errors++; $display("FAIL read_stable: got 0 expected 1"); end
  endtask

  task automatic test_write();
    // Read first so that m1_rdata holds a known value the write must leave alone.
    m1_addr = 25'h0000300; m1_wmask = 4'h0; m1_wdata = 32'h0; m1_valid = 1'b1;
    serve(3, 32'hCAFEF00D);
    m1_valid = 1'b0;
    checks++;
    if (s_rdy !== 2'b10 || s_rd1 !== 32'hCAFEF00D) begin
      errors++; $display("FAIL m1_read: got rdy=%b rd1=%h expected 10/cafef00d", s_rdy, s_rd1);
    end
    @(negedge clk);
    m1_addr = 25'h0000206; m1_wmask = 4'b0011; m1_wdata = 32'h12345678; m1_valid = 1'b1;
    serve(6, 32'h99999999);
    m1_valid = 1'b0;
    checks++;
    if (s_addr !== 25'h0000204 || s_din !== 32'h12345678 || s_wmask !== 4'b0011) begin
      errors++;
      $display("FAIL write_fields: got addr=%h din=%h wm=%b expected 0000204/12345678/0011",
               s_addr, s_din, s_wmask);
    end
    checks++;
    if (!s_stable) begin errors++; $display("FAIL write_stable: got 0 expected 1"); end
    checks++;
    if (s_rdy !== 2'b10 || s_rd1 !== 32'hCAFEF00D || s_rd0 !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL write_rdata: got rdy=%b rd1=%h rd0=%h expected 10/cafef00d/deadbeef",
               s_rdy, s_rd1, s_rd0);
    end
  endtask

  task automatic test_tie();
    logic [1:0] exp_rdy [5];
`ifdef SDRAM_ARB_FIXED_PRIO_EN
    exp_rdy = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b01};
`else
    exp_rdy = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01};
`endif
    apply_reset();
    m0_addr = 25'h0001000; m0_wmask = 4'h0; m0_wdata = 32'h0;
    m1_addr = 25'h0002000; m1_wmask = 4'h0; m1_wdata = 32'h0;
    m0_valid = 1'b1; m1_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i == 4) m1_valid = 1'b0;
      serve(2, 32'h100 + i);
      checks++;
      if (s_rdy !== exp_rdy[i] || s_addr !== (exp_rdy[i][1] ? 25'h0002000 : 25'h0001000)) begin
        errors++;
        $display("FAIL tie_order[%0d]: got rdy=%b addr=%h expected rdy=%b", i, s_rdy, s_addr,
                 exp_rdy[i]);
      end
    end
    m0_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_handshake();
    m0_addr = 25'h0000044; m0_wmask = 4'b1111; m0_wdata = 32'hA0A0A0A0; m0_valid = 1'b1;
    serve(5, 32'h0);
    checks++;
    if (s_vld_after !== 1'b0) begin
      errors++; $display("FAIL hs_valid_k1: got %b expected 0", s_vld_after);
    end
    checks++;
    if (!s_stable) begin errors++; $display("FAIL hs_stable: got 0 expected 1"); end
    // Request still held: no grant is made in DONE, and the next grant lands at k+2.
    checks++;
    if (mem_valid !== 1'b0) begin
      errors++; $display("FAIL hs_no_grant_done: got %b expected 0", mem_valid);
    end
    @(negedge clk);
    checks++;
    if (mem_valid !== 1'b1) begin
      errors++; $display("FAIL hs_regrant_k2: got %b expected 1", mem_valid);
    end
    serve(1, 32'h0);
    m0_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_spurious();
    logic [31:0] rd0, rd1;
    logic        seen;
    rd0 = m0_rdata;
    rd1 = m1_rdata;
    seen = 1'b0;
    mem_dout = 32'h55555555;
    mem_ready = 1'b1;
    @(negedge clk);
    seen = seen | m0_ready | m1_ready;
    mem_ready = 1'b0;
    mem_dout = 32'h0;
    @(negedge clk);
    seen = seen | m0_ready | m1_ready;
    checks++;
    if (seen !== 1'b0 || mem_valid !== 1'b0) begin
      errors++; $display("FAIL spurious_ready: got ready=%b valid=%b expected 0/0", seen, mem_valid);
    end
    checks++;
    if (m0_rdata !== rd0 || m1_rdata !== rd1) begin
      errors++; $display("FAIL spurious_rdata: got %h/%h expected %h/%h", m0_rdata, m1_rdata, rd0, rd1);
    end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    m0_addr = 25'h0000080; m0_wmask = 4'b0001; m0_wdata = 32'h11223344; m0_valid = 1'b1;
    while (mem_valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (mem_valid !== 1'b1) begin errors++; $display("FAIL rmid_grant: got 0 expected 1"); end
    repeat (3) @(negedge clk);
    #2 resetn = 1'b0;
    m0_valid = 1'b0;
    #1;
    checks++;
    if ({mem_valid, mem_addr, mem_din, mem_wmask, m0_ready, m1_ready, m0_rdata, m1_rdata}
        !== '0) begin
      errors++;
      $display("FAIL rmid_async: got valid=%b addr=%h din=%h wm=%h rd0=%h rd1=%h expected all zero",
               mem_valid, mem_addr, mem_din, mem_wmask, m0_rdata, m1_rdata);
    end
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    m0_addr = 25'h0000040; m0_wmask = 4'h0; m0_valid = 1'b1;
    serve(4, 32'hA5A5A5A5);
    m0_valid = 1'b0;
    checks++;
    if (!s_ok || s_addr !== 25'h0000040 || s_rdy !== 2'b01 || s_rd0 !== 32'hA5A5A5A5) begin
      errors++;
      $display("FAIL rmid_after: got ok=%b addr=%h rdy=%b rd0=%h expected 1/0000040/01/a5a5a5a5",
               s_ok, s_addr, s_rdy, s_rd0);
    end
  endtask

  initial begin
    resetn = 1'b0;
    m0_valid = 1'b0; m0_addr = '0; m0_wdata = '0; m0_wmask = '0;
    m1_valid = 1'b0; m1_addr = '0; m1_wdata = '0; m1_wmask = '0;
    mem_dout = '0; mem_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_single_read();
    test_write();
    test_tie();
    test_handshake();
    test_spurious();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
